// File: rtl/risc_v_mike_seq.sv
// -----------------------------------------------------------------------------
// risc_v_mike_seq -- multi-cycle sequencer for the risc_v_mike core.
//
// Each instruction is stepped through FETCH, DECODE, EXEC, optional MEM, and WB.
// The sequencer owns the PC, the instruction register and the instruction and
// data memory request/acknowledge handshakes. It also gates the side effects of
// the combinational decoder and ALU:
//   - a register-file write (rf_we) happens only in WB;
//   - a data request (dmem_req/dmem_we) happens only in MEM;
//   - a PC update happens only in WB.
//
// Every output is decoded from registered state. No input reaches an output
// through combinational logic.
//
// Ports:
//   clk, rst_n             core clock (rising edge), async active-low reset
//   imem_req/addr/ack/rdata instruction fetch handshake (addr = pc)
//   instruction, pc        instruction register and program counter
//   pc_src, branch_target  decoder branch decision and target
//   mem_read, mem_write    decoder load/store indication
//   reg_write              decoder: instruction writes rd
//   dmem_req/we/ack        data memory handshake
//   rf_we                  register-file write enable, asserted only in WB
//   retire                 one-cycle pulse per completed instruction
//   halt_req, halted       stop request (sampled in WB/HALT) and HALT status
//   bus_err                sticky memory-timeout flag
//   state                  current FSM state, for debug
//
// Build option: define RISC_V_MIKE_SEQ_TIMEOUT_EN to bound memory waits.
// After TIMEOUT_CYC cycles without an acknowledge, the sequencer sets bus_err
// and enters HALT. When the macro is undefined, waits are unbounded and
// bus_err is tied low.
// -----------------------------------------------------------------------------
module risc_v_mike_seq #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       INSTR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(32'h0000_0000),
    parameter int unsigned       TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pc,
    input  logic               pc_src,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               reg_write,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic               rf_we,
    output logic               retire,
    input  logic               halt_req,
    output logic               halted,
    output logic               bus_err,
    output logic [2:0]         state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(32'd4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(32'd3);

    logic [2:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    // rf_we and dmem_we are registered. The decoder inputs are sampled on the
    // transition into WB/MEM. They are stable there, because they derive from
    // the instruction register, which is frozen after FETCH.
    logic               rf_we_q, rf_we_d;
    logic               dmem_we_q, dmem_we_d;
    logic               wait_expired_s;

`ifdef RISC_V_MIKE_SEQ_TIMEOUT_EN
    localparam int unsigned WAIT_LIMIT = (TIMEOUT_CYC == 0) ? 1 : TIMEOUT_CYC;
    localparam int unsigned CNT_W      = (WAIT_LIMIT > 255) ? $clog2(WAIT_LIMIT + 1) : 8;
    // The count equals the number of previous unacknowledged cycles. Expiry
    // therefore falls on the WAIT_LIMIT-th waiting cycle.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
    logic             mem_wait_s;

    assign mem_wait_s     = ((state_q == S_FETCH) && !imem_ack) ||
                            ((state_q == S_MEM)   && !dmem_ack);
    // An acknowledge in the expiry cycle clears mem_wait_s, so the ack wins.
    assign wait_expired_s = mem_wait_s && (cnt_q == WAIT_LAST);

    // Wait counter and sticky error next-state.
    always_comb begin
        cnt_d     = {CNT_W{1'b0}};
        bus_err_d = bus_err_q | wait_expired_s;
        if (mem_wait_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Wait counter and bus error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= {CNT_W{1'b0}};
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign wait_expired_s = 1'b0;
    assign bus_err        = 1'b0;
`endif

    // Sequencer next-state, PC, instruction register and gated strobes.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        rf_we_d   = 1'b0;
        dmem_we_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end else if (wait_expired_s) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (mem_read || mem_write) begin
                    state_d   = S_MEM;
                    dmem_we_d = mem_write;
                end else begin
                    state_d = S_WB;
                    rf_we_d = reg_write;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = S_WB;
                    rf_we_d = reg_write;
                end else if (wait_expired_s) begin
                    state_d = S_HALT;
                end else begin
                    state_d   = S_MEM;
                    dmem_we_d = dmem_we_q;
                end
            end
            S_WB: begin
                // The branch target is word-aligned. The sequential PC increment
                // wraps naturally at ADDR_W bits.
                if (pc_src) begin
                    pc_d = branch_target & ALIGN_MASK;
                end else begin
                    pc_d = pc_q + PC_STEP;
                end
                if (halt_req) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                if (!halt_req) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_HALT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= {INSTR_W{1'b0}};
            rf_we_q   <= 1'b0;
            dmem_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            rf_we_q   <= rf_we_d;
            dmem_we_q <= dmem_we_d;
        end
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign dmem_req    = (state_q == S_MEM);
    assign dmem_we     = dmem_we_q;
    assign rf_we       = rf_we_q;
    assign retire      = (state_q == S_WB);
    assign halted      = (state_q == S_HALT);
    assign state       = state_q;

endmodule

// File: tb/tb_risc_v_mike_seq.sv
// Directed testbench for risc_v_mike_seq. Each step advances one clock edge,
// then observes the outputs 1 time unit later. Inputs change at that same
// point, well before the next active edge.
module tb_risc_v_mike_seq;

    localparam logic [31:0] I_ADD = 32'h0020_81B3;
    localparam logic [31:0] I_NOP = 32'h0000_0013;
    localparam logic [31:0] I_SW  = 32'h0020_A023;
    localparam logic [31:0] I_BEQ = 32'h0020_8463;
    localparam logic [31:0] I_LW  = 32'h0000_A183;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        mem_read, mem_write, reg_write;
    logic        dmem_req, dmem_we, dmem_ack;
    logic        rf_we, retire;
    logic        halt_req, halted, bus_err;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;

    risc_v_mike_seq #(
        .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0000_0000), .TIMEOUT_CYC(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instruction(instruction), .pc(pc),
        .pc_src(pc_src), .branch_target(branch_target),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .retire(retire), .halt_req(halt_req), .halted(halted),
        .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; pc_src = 1'b0;
        branch_target = 32'h0; mem_read = 1'b0; mem_write = 1'b0;
        reg_write = 1'b0; dmem_ack = 1'b0; halt_req = 1'b0;
        step(); step();

        // Reset state
        chk("rst_state", state, 3'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_dmem_req", dmem_req, 1'b0);
        chk("rst_dmem_we", dmem_we, 1'b0);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_retire", retire, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_bus_err", bus_err, 1'b0);

        // ADD at pc 0 with zero-wait fetch
        imem_ack = 1'b1; imem_rdata = I_ADD; reg_write = 1'b1;
        rst_n = 1'b1;
        step();                                     // FETCH entry (cycle 1)
        chk("add_fetch_state", state, 3'd1);
        chk("add_imem_req", imem_req, 1'b1);
        chk("add_imem_addr", imem_addr, 32'h0);
        step();                                     // DECODE (cycle 2)
        chk("add_decode_state", state, 3'd2);
        chk("add_ir", instruction, I_ADD);
        chk("add_no_rf_we_decode", rf_we, 1'b0);
        step();                                     // EXEC (cycle 3)
        chk("add_no_retire_exec", retire, 1'b0);
        chk("add_no_rf_we_exec", rf_we, 1'b0);
        step();                                     // WB (cycle 4)
        chk("add_retire", retire, 1'b1);
        chk("add_rf_we", rf_we, 1'b1);
        chk("add_pc_in_wb", pc, 32'h0);
        step();
        chk("add_next_fetch", state, 3'd1);
        chk("add_pc", pc, 32'h4);
        chk("add_retire_drop", retire, 1'b0);
        chk("add_rf_we_drop", rf_we, 1'b0);

        // NOP at pc 4, reg_write low
        imem_rdata = I_NOP; reg_write = 1'b0;
        step();
        chk("nop_ir", instruction, I_NOP);
        step(); step();
        chk("nop_retire", retire, 1'b1);
        chk("nop_rf_we", rf_we, 1'b0);
        step();
        chk("nop_pc", pc, 32'h8);

        // Store at pc 8; dmem_ack delayed by 3 cycles
        imem_rdata = I_SW; mem_write = 1'b1;       // FETCH is cycle 1
        step();                                     // cycle 2 DECODE
        imem_ack = 1'b0;
        step();                                     // cycle 3 EXEC
        chk("sw_exec_no_dreq", dmem_req, 1'b0);
        for (int k = 0; k < 4; k++) begin           // cycles 4..7 MEM
            step();
            if (k == 3) dmem_ack = 1'b1;
            chk("sw_dmem_req", dmem_req, 1'b1);
            chk("sw_dmem_we", dmem_we, 1'b1);
            chk("sw_rf_we_mem", rf_we, 1'b0);
            chk("sw_retire_mem", retire, 1'b0);
        end
        step();                                     // cycle 8 WB
        dmem_ack = 1'b0; mem_write = 1'b0;
        chk("sw_retire", retire, 1'b1);
        chk("sw_rf_we", rf_we, 1'b0);
        chk("sw_dreq_drop", dmem_req, 1'b0);
        chk("sw_dwe_drop", dmem_we, 1'b0);
        step();
        chk("sw_pc", pc, 32'hC);

        // Taken branch to 0x103, aligned to 0x100
        imem_ack = 1'b1; imem_rdata = I_BEQ; pc_src = 1'b1;
        branch_target = 32'h0000_0103;
        step(); step(); step();
        chk("beq_retire", retire, 1'b1);
        step();
        chk("beq_pc", pc, 32'h0000_0100);
        chk("beq_imem_addr", imem_addr, 32'h0000_0100);

        // Branch to the top word, then wrap with a plain increment
        branch_target = 32'hFFFF_FFFE;
        step(); step(); step(); step();
        chk("top_pc", pc, 32'hFFFF_FFFC);
        pc_src = 1'b0; imem_rdata = I_ADD;
        step(); step(); step(); step();
        chk("wrap_pc", pc, 32'h0);

        // Halt request raised in DECODE and held
        reg_write = 1'b1;
        step();                                     // DECODE
        halt_req = 1'b1;
        step(); step();                             // EXEC, WB
        chk("halt_retire", retire, 1'b1);
        chk("halt_rf_we", rf_we, 1'b1);
        chk("halt_not_yet", halted, 1'b0);
        step();
        chk("halt_state", state, 3'd6);
        chk("halt_halted", halted, 1'b1);
        chk("halt_no_ireq", imem_req, 1'b0);
        chk("halt_no_dreq", dmem_req, 1'b0);
        step();
        chk("halt_hold", halted, 1'b1);
        chk("halt_pc", pc, 32'h4);
        halt_req = 1'b0;
        step();
        chk("resume_state", state, 3'd1);
        chk("resume_addr", imem_addr, 32'h4);

        // Reset asserted during a load's MEM phase
        imem_rdata = I_LW; mem_read = 1'b1;
        step(); step();                             // DECODE, EXEC
        imem_ack = 1'b0;
        step();                                     // MEM
        chk("lw_dmem_req", dmem_req, 1'b1);
        chk("lw_dmem_we", dmem_we, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_dmem_req", dmem_req, 1'b0);
        chk("async_state", state, 3'd0);
        chk("async_pc", pc, 32'h0);
        chk("async_ir", instruction, 32'h0);
        chk("async_retire", retire, 1'b0);
        step();
        chk("async_no_retire", retire, 1'b0);
        mem_read = 1'b0; reg_write = 1'b0; imem_rdata = I_ADD;

`ifdef RISC_V_MIKE_SEQ_TIMEOUT_EN
        // An ack arriving on the 4th wait cycle wins
        rst_n = 1'b1;
        step(); step(); step(); step();             // FETCH waits 1..4
        chk("to_race_state", state, 3'd1);
        imem_ack = 1'b1;
        step();
        chk("to_race_decode", state, 3'd2);
        chk("to_race_bus_err", bus_err, 1'b0);
        imem_ack = 1'b0;
        step(); step(); step();                     // EXEC, WB, FETCH @4
        chk("to_fetch_pc", pc, 32'h4);
        step(); step(); step();
        chk("to_wait4_state", state, 3'd1);
        chk("to_wait4_bus_err", bus_err, 1'b0);
        step();
        chk("to_halt_state", state, 3'd6);
        chk("to_halted", halted, 1'b1);
        chk("to_bus_err", bus_err, 1'b1);
        chk("to_no_ireq", imem_req, 1'b0);
        step();
        chk("to_resume_state", state, 3'd1);
        chk("to_resume_addr", imem_addr, 32'h4);
        chk("to_sticky", bus_err, 1'b1);
        imem_ack = 1'b1;
        step(); step(); step();
        chk("to_sticky_wb", bus_err, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("to_cleared", bus_err, 1'b0);
`else
        // Unbounded fetch wait: no timeout, no halt, no error
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) step();
        chk("nto_state", state, 3'd1);
        chk("nto_imem_req", imem_req, 1'b1);
        chk("nto_halted", halted, 1'b0);
        chk("nto_bus_err", bus_err, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
